// File: rtl/conv_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : conv_operand_loader
//  Description : Unpacks a serial valid/ready stream of signed samples into
//                the parallel A (M taps) and B (N taps) operand buses of the
//                convolution engine, pulses conv_start for one cycle and then
//                holds the operands stable until conv_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_operand_loader #(
    parameter int M = 6,
    parameter int N = 8,
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic [W-1:0]     s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [M*W-1:0]   a_flat,
    output logic [N*W-1:0]   b_flat,
    output logic             conv_start,
    input  logic             conv_done,
    output logic             busy,
    output logic             frame_err
);

    // Index wide enough to name any sample position 0..M+N-1.
    localparam int              c_IW       = $clog2(M + N);
    localparam logic [c_IW-1:0] c_LAST_POS = c_IW'(M + N - 1);
    localparam logic [c_IW-1:0] c_A_LAST   = c_IW'(M - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    state_t          r_state;
    logic [c_IW-1:0] r_idx;

    logic            w_xfer;
    logic [c_IW-1:0] w_pos;
    logic            w_final;
    logic            w_early;
    logic            w_end;

    // Position of the sample being offered within the frame, and its framing class.
    always_comb begin
        w_xfer = s_valid & s_ready;
        w_pos  = '0;
        case (r_state)
            S_LOAD_A: w_pos = r_idx;
            S_LOAD_B: w_pos = r_idx + c_IW'(M);
            default:  w_pos = '0;
        endcase
        w_final = (w_pos == c_LAST_POS);
        w_early = s_last & ~w_final;
        w_end   = s_last | w_final;
    end

    // Operand registers: write the accepted sample; on an early s_last also
    // clear every tap that lies beyond it in the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_flat <= '0;
            b_flat <= '0;
        end else if (w_xfer) begin
            for (int k = 0; k < M; k++) begin
                if (c_IW'(k) == w_pos)
                    a_flat[k*W +: W] <= s_data;
                else if (w_early && (c_IW'(k) > w_pos))
                    a_flat[k*W +: W] <= '0;
            end
            for (int k = 0; k < N; k++) begin
                if (c_IW'(M + k) == w_pos)
                    b_flat[k*W +: W] <= s_data;
                else if (w_early && (c_IW'(M + k) > w_pos))
                    b_flat[k*W +: W] <= '0;
            end
        end
    end

    // Frame sequencing FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            s_ready    <= 1'b0;
            conv_start <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_LOAD_A, S_LOAD_B: begin
                    s_ready <= 1'b1;
                    if (w_xfer) begin
                        busy <= 1'b1;
                        if (w_end) begin
                            // Frame closes: either the last tap or an early s_last.
                            r_state    <= S_START;
                            r_idx      <= '0;
                            s_ready    <= 1'b0;
                            conv_start <= 1'b1;
                            if (s_last != w_final)
                                frame_err <= 1'b1;
                        end else if (w_pos == c_A_LAST) begin
                            r_state <= S_LOAD_B;
                            r_idx   <= '0;
                        end else begin
                            r_state <= (r_state == S_LOAD_B) ? S_LOAD_B : S_LOAD_A;
                            r_idx   <= r_idx + c_IW'(1);
                        end
                    end
                end
                S_START: begin
                    conv_start <= 1'b0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (conv_done) begin
                        r_state <= S_IDLE;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_idx      <= '0;
                    s_ready    <= 1'b0;
                    conv_start <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
